// File: rtl/multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : multicycle_control                                       |
// | Description : Moore sequencing FSM for a multicycle MIPS datapath.     |
// |               Steps each instruction through fetch, decode, execute,   |
// |               memory and writeback, stalling on a shared memory port.  |
// |               Optional performance counters under MC_CTRL_PERF_EN.     |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module multicycle_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic [1:0]  reg_dst,
   output logic [1:0]  mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic [3:0]  state,
   output logic        illegal,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt,
   output logic [31:0] stall_cnt
);

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_j     = 6'b000010;
   localparam logic [5:0] c_op_jal   = 6'b000011;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_bne   = 6'b000101;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_fn_jr    = 6'b001000;

   typedef enum logic [3:0] {
      BOOT   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MEMADR = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      EXEC   = 4'd7,
      RWB    = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      BRANCH = 4'd11,
      JUMP   = 4'd12,
      JR     = 4'd13
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_dec_bad;
   logic   r_illegal;

   // State register; reset drops straight to BOOT so strobes fall immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= BOOT;
      else        r_state <= w_next;
   end

   // Next-state and Moore output decode (FETCH/BRANCH strobes also see inputs)
   always_comb begin
      w_next     = r_state;
      w_dec_bad  = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_source  = 2'b00;
      case (r_state)
         BOOT: w_next = FETCH;
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) w_next = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               c_op_lw, c_op_sw: w_next = MEMADR;
               c_op_rtype:       w_next = (funct == c_fn_jr) ? JR : EXEC;
               c_op_addi:        w_next = ADDIEX;
               c_op_beq, c_op_bne: w_next = BRANCH;
               c_op_j, c_op_jal: w_next = JUMP;
               default: begin
                  w_dec_bad = 1'b1;
                  w_next    = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            w_next    = (opcode == c_op_lw) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) w_next = MEMWB;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            w_next     = FETCH;
         end
         MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) w_next = FETCH;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            w_next    = RWB;
         end
         RWB: begin
            reg_write = 1'b1;
            reg_dst   = 2'b01;
            w_next    = FETCH;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            w_next    = ADDIWB;
         end
         ADDIWB: begin
            reg_write = 1'b1;
            w_next    = FETCH;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_source = 2'b01;
            // opcode[0] distinguishes bne from beq, inverting the taken sense
            pc_write  = zero ^ opcode[0];
            w_next    = FETCH;
         end
         JUMP: begin
            pc_source = 2'b10;
            pc_write  = 1'b1;
            if (opcode == c_op_jal) begin
               reg_write  = 1'b1;
               reg_dst    = 2'b10;
               mem_to_reg = 2'b10;
            end
            w_next = FETCH;
         end
         JR: begin
            pc_source = 2'b11;
            pc_write  = 1'b1;
            w_next    = FETCH;
         end
         default: w_next = BOOT;
      endcase
   end

   // Sticky unsupported-opcode flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_illegal <= 1'b0;
      else if (w_dec_bad) r_illegal <= 1'b1;
   end

   assign illegal = r_illegal;
   assign state   = r_state;

`ifdef MC_CTRL_PERF_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instr_cnt;
   logic [31:0] r_stall_cnt;

   // Free-running performance counters, wrapping modulo 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt <= 32'd0;
         r_instr_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (r_state != BOOT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (ir_write)        r_instr_cnt <= r_instr_cnt + 32'd1;
         if ((mem_read || mem_write) && !mem_ready)
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
   assign instr_cnt = r_instr_cnt;
   assign stall_cnt = r_stall_cnt;
`else
   assign cycle_cnt = 32'd0;
   assign instr_cnt = 32'd0;
   assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_multicycle_control                                    |
// | Description : Self-checking bench for multicycle_control. Each         |
// |               instruction is expanded into its expected per-cycle      |
// |               control trace and compared cycle by cycle.               |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
   logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
   logic        alu_src_a;
   logic [3:0]  state;
   logic        illegal;
   logic [31:0] cycle_cnt, instr_cnt, stall_cnt;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state(state), .illegal(illegal),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

`ifdef MC_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   int n_pass  = 0;
   int n_total = 0;
   logic        exp_illegal = 1'b0;
   logic [31:0] exp_cyc = 0, exp_ins = 0, exp_stl = 0;

   wire [16:0] obs_ctl = {pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                          reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

   // Control word built from named fields, in obs_ctl order
   function automatic logic [16:0] mk(input logic pcw, irw, io, mr, mw, rw,
                                      input logic [1:0] rd, m2r, input logic asa,
                                      input logic [1:0] asb, aop, ps);
      return {pcw, irw, io, mr, mw, rw, rd, m2r, asa, asb, aop, ps};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock cycle: drive inputs, compare at the falling edge, then advance
   task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] ctl,
                      input logic mr, input logic z);
      mem_ready = mr;
      zero      = z;
      @(negedge clk);
      check({tag, ".state"}, 32'(state), 32'(st));
      check({tag, ".ctl"}, 32'(obs_ctl), 32'(ctl));
      check({tag, ".illegal"}, 32'(illegal), 32'(exp_illegal));
      check({tag, ".cycle_cnt"}, cycle_cnt, exp_cyc);
      check({tag, ".instr_cnt"}, instr_cnt, exp_ins);
      check({tag, ".stall_cnt"}, stall_cnt, exp_stl);
      if (PERF) begin
         if (st != 4'd0) exp_cyc++;
         if (ctl[15]) exp_ins++;
         if ((ctl[13] || ctl[12]) && !mr) exp_stl++;
      end
      @(posedge clk);
      #1;
   endtask

   // Expected trace for one instruction, derived from its class
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fwait, input int mwait, input logic z);
      logic [16:0] c_fetch, c_dec, c_addr;
      bit taken;
      c_fetch = mk(0,0,0,1,0,0,2'b00,2'b00,0,2'b01,2'b00,2'b00);
      c_dec   = mk(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,2'b00,2'b00);
      c_addr  = mk(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,2'b00,2'b00);
      opcode = op;
      funct  = fn;
      for (int i = 0; i < fwait; i++) cyc("fetch_wait", 4'd1, c_fetch, 1'b0, 1'($urandom));
      cyc("fetch", 4'd1, c_fetch | mk(1,1,0,0,0,0,2'b00,2'b00,0,2'b00,2'b00,2'b00),
          1'b1, 1'($urandom));
      cyc("decode", 4'd2, c_dec, 1'($urandom), 1'($urandom));
      case (op)
         6'b000000: begin
            if (fn == 6'b001000)
               cyc("jr", 4'd13, mk(1,0,0,0,0,0,2'b00,2'b00,0,2'b00,2'b00,2'b11),
                   1'($urandom), 1'($urandom));
            else begin
               cyc("exec", 4'd7, mk(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,2'b10,2'b00),
                   1'($urandom), 1'($urandom));
               cyc("rwb", 4'd8, mk(0,0,0,0,0,1,2'b01,2'b00,0,2'b00,2'b00,2'b00),
                   1'($urandom), 1'($urandom));
            end
         end
         6'b001000: begin
            cyc("addiex", 4'd9, c_addr, 1'($urandom), 1'($urandom));
            cyc("addiwb", 4'd10, mk(0,0,0,0,0,1,2'b00,2'b00,0,2'b00,2'b00,2'b00),
                1'($urandom), 1'($urandom));
         end
         6'b100011: begin
            cyc("lw_adr", 4'd3, c_addr, 1'($urandom), 1'($urandom));
            for (int i = 0; i < mwait; i++)
               cyc("memrd_wait", 4'd4, mk(0,0,1,1,0,0,2'b00,2'b00,0,2'b00,2'b00,2'b00),
                   1'b0, 1'($urandom));
            cyc("memrd", 4'd4, mk(0,0,1,1,0,0,2'b00,2'b00,0,2'b00,2'b00,2'b00),
                1'b1, 1'($urandom));
            cyc("memwb", 4'd5, mk(0,0,0,0,0,1,2'b00,2'b01,0,2'b00,2'b00,2'b00),
                1'($urandom), 1'($urandom));
         end
         6'b101011: begin
            cyc("sw_adr", 4'd3, c_addr, 1'($urandom), 1'($urandom));
            for (int i = 0; i < mwait; i++)
               cyc("memwr_wait", 4'd6, mk(0,0,1,0,1,0,2'b00,2'b00,0,2'b00,2'b00,2'b00),
                   1'b0, 1'($urandom));
            cyc("memwr", 4'd6, mk(0,0,1,0,1,0,2'b00,2'b00,0,2'b00,2'b00,2'b00),
                1'b1, 1'($urandom));
         end
         6'b000100, 6'b000101: begin
            taken = (op == 6'b000100) ? z : !z;
            cyc("branch", 4'd11, mk(taken,0,0,0,0,0,2'b00,2'b00,1,2'b00,2'b01,2'b01),
                1'($urandom), z);
         end
         6'b000010:
            cyc("j", 4'd12, mk(1,0,0,0,0,0,2'b00,2'b00,0,2'b00,2'b00,2'b10),
                1'($urandom), 1'($urandom));
         6'b000011:
            cyc("jal", 4'd12, mk(1,0,0,0,0,1,2'b10,2'b10,0,2'b00,2'b00,2'b10),
                1'($urandom), 1'($urandom));
         default: exp_illegal = 1'b1;
      endcase
   endtask

   function automatic logic [5:0] pick_illegal();
      logic [5:0] op;
      do op = 6'($urandom);
      while (op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2b});
      return op;
   endfunction

   initial begin
      logic [5:0] op, fn;
      rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.state", 32'(state), 32'd0);
      check("reset.ctl", 32'(obs_ctl), 32'd0);
      check("reset.illegal", 32'(illegal), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc("boot", 4'd0, 17'd0, 1'b1, 1'b0);

      // Directed: add, lw with 2 waits, beq/bne with zero=1, jal, jr, illegal
      run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);
      run_instr(6'b100011, 6'b000000, 0, 2, 1'b0);
      run_instr(6'b000100, 6'b000000, 0, 0, 1'b1);
      run_instr(6'b000101, 6'b000000, 0, 0, 1'b1);
      run_instr(6'b000011, 6'b000000, 1, 0, 1'b0);
      run_instr(6'b000000, 6'b001000, 0, 0, 1'b0);
      run_instr(6'b111111, 6'b000000, 0, 0, 1'b0);

      // Randomized instruction mix with random memory waits
      for (int k = 0; k < 60; k++) begin
         fn = 6'($urandom);
         case ($urandom_range(0, 9))
            0: begin op = 6'h00; if (fn == 6'b001000) fn = 6'b100000; end
            1: begin op = 6'h00; fn = 6'b001000; end
            2: op = 6'h08;
            3: op = 6'h23;
            4: op = 6'h2b;
            5: op = 6'h04;
            6: op = 6'h05;
            7: op = 6'h02;
            8: op = 6'h03;
            default: op = pick_illegal();
         endcase
         run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
      end

      // Reset asserted in the middle of a MEMWR wait
      opcode = 6'b101011;
      cyc("rst_fetch", 4'd1, mk(1,1,0,1,0,0,2'b00,2'b00,0,2'b01,2'b00,2'b00), 1'b1, 1'b0);
      cyc("rst_decode", 4'd2, mk(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,2'b00,2'b00), 1'b0, 1'b0);
      cyc("rst_adr", 4'd3, mk(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,2'b00,2'b00), 1'b0, 1'b0);
      mem_ready = 1'b0;
      @(negedge clk);
      check("pre_rst.mem_write", 32'(mem_write), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async.mem_write", 32'(mem_write), 32'd0);
      check("rst_async.state", 32'(state), 32'd0);
      check("rst_async.illegal", 32'(illegal), 32'd0);
      check("rst_async.cycle_cnt", cycle_cnt, 32'd0);
      exp_illegal = 1'b0; exp_cyc = 0; exp_ins = 0; exp_stl = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc("boot2", 4'd0, 17'd0, 1'b0, 1'b0);

      // Three zero-wait instructions: add, sw, j
      run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);
      run_instr(6'b101011, 6'b000000, 0, 0, 1'b0);
      run_instr(6'b000010, 6'b000000, 0, 0, 1'b0);
      mem_ready = 1'b0;
      @(negedge clk);
      check("perf.cycle_cnt", cycle_cnt, PERF ? 32'd11 : 32'd0);
      check("perf.instr_cnt", instr_cnt, PERF ? 32'd3 : 32'd0);
      check("perf.stall_cnt", stall_cnt, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle MIPS datapath. It replaces single-cycle opcode decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. Instruction fetch and data access share one memory port, so every memory state stalls on a `mem_ready` handshake. It drives the PC, IR, register-file, ALU-mux and memory strobes. Supported instructions: R-type, addi, lw, sw, beq, bne, j, jal, jr.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  IR[31:26]; stable from DECODE until the next FETCH completes
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag, combinational from the current ALU operation
- `mem_ready`  in  1  memory completes the current read or write this cycle
- `pc_write`  out  1  load PC
- `ir_write`  out  1  load IR and MDR from memory read data
- `iord`  out  1  memory address mux select: 0 = PC, 1 = ALUOut
- `mem_read`, `mem_write`  out  1  memory strobes
- `reg_write`  out  1  register-file write enable
- `reg_dst`  out  2  write-register select: 00 = rt, 01 = rd, 10 = $31
- `mem_to_reg`  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC
- `alu_src_a`  out  1  0 = PC, 1 = rs
- `alu_src_b`  out  2  00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- `alu_op`  out  2  00 = add, 01 = sub, 10 = decode by funct
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs
- `state`  out  4  current state, for debug
- `illegal`  out  1  sticky flag: an unsupported opcode was decoded
- `cycle_cnt`, `instr_cnt`, `stall_cnt`  out  32  performance counters (see Configuration)

## Operation
- States and encodings:
  - BOOT=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - EXEC=7, RWB=8, ADDIEX=9, ADDIWB=10, BRANCH=11, JUMP=12, JR=13
- Outputs are a Moore decode of `state`. Exceptions: `pc_write` and `ir_write` in FETCH, and `pc_write` in BRANCH. Any output not listed for a state is 0.
- BOOT: all outputs 0. Next state is FETCH.
- FETCH:
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Holds until `mem_ready`=1, then goes to DECODE.
- DECODE:
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target lands in ALUOut).
  - Next state by instruction: lw/sw → MEMADR; R-type with funct 001000 → JR; other R-type → EXEC; addi → ADDIEX; beq/bne → BRANCH; j/jal → JUMP.
  - Any other opcode sets `illegal` and goes to FETCH.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: `mem_read`=1, `iord`=1. Goes to MEMWB on `mem_ready`.
- MEMWB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01. Next: FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Goes to FETCH on `mem_ready`.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next: RWB.
- RWB: `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00. Next: FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next: ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00. Next: FETCH.
- BRANCH:
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01.
  - `pc_write` = `zero` XOR `opcode[0]`: beq taken on zero=1, bne taken on zero=0.
  - Next: FETCH.
- JUMP:
  - Outputs: `pc_source`=10, `pc_write`=1.
  - jal (opcode 000011) additionally drives `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10; PC already holds PC+4.
  - Next: FETCH.
- JR: `pc_source`=11, `pc_write`=1. Next: FETCH.
- `illegal` is cleared only by reset.

## Timing
- Reset:
  - Asserting `rst_n` forces BOOT asynchronously, so all strobes drop immediately, including mid-handshake in MEMRD/MEMWR/FETCH.
  - `illegal` and all counters reset to 0.
- After `rst_n` deasserts, the first FETCH begins 1 cycle later (BOOT lasts exactly 1 cycle).
- Zero-wait latency in cycles:
  - 5: lw
  - 4: sw, R-type, addi
  - 3: beq, bne, j, jal, jr
  - 2: illegal opcode
- Each memory wait cycle adds 1 cycle. Memory strobes stay asserted and stable while `mem_ready`=0.
- `mem_ready` is ignored in states without a memory strobe.

## Configuration
- Macro: `MC_CTRL_PERF_EN`.
- Defined:
  - `cycle_cnt` increments every cycle outside BOOT.
  - `instr_cnt` increments on each cycle with `ir_write`=1.
  - `stall_cnt` increments on each cycle with (`mem_read` or `mem_write`) and `mem_ready`=0.
  - All three wrap modulo 2^32.
- Undefined: the counter registers are not built; the three ports are tied to 0.

## Test plan
- Reset, then zero-wait add (opcode 0, funct 100000) → states 0,1,2,7,8,1; `reg_write`=1 with `reg_dst`=01 in RWB only.
- lw with `mem_ready` low for 2 cycles in MEMRD → `mem_read`=1 and `iord`=1 for 3 cycles; MEMWB writes with `mem_to_reg`=01; total 7 cycles.
- Taken vs not-taken branches:
  - beq with `zero`=1 → `pc_write`=1, `pc_source`=01 in BRANCH.
  - bne with `zero`=1 → `pc_write`=0.
- jal → JUMP drives `pc_write`=1, `reg_dst`=10, `mem_to_reg`=10. jr (funct 001000) → JR state, `reg_write` stays 0 throughout.
- Robustness:
  - Opcode 111111 → `illegal`=1 and returns to FETCH after DECODE.
  - `rst_n` pulsed low during MEMWR wait → `mem_write` drops the same cycle, state 0, `illegal`=0.
- With `MC_CTRL_PERF_EN` defined: 3 zero-wait instructions (add, sw, j) → `instr_cnt`=3, `stall_cnt`=0, `cycle_cnt`=11.
